// File: rtl/result_bcd_converter.sv
// result_bcd_converter: sequential shift-add-3 binary-to-BCD converter for the calculator result path
//   clk, rst (async, active-low)
//   start, bin_in, signed_mode : conversion request and operand
//   busy, done                 : handshake (done is a one-cycle pulse when the outputs update)
//   dig3..dig0, neg, ovf       : registered BCD digits (thousands..units), sign, magnitude > 9999
module result_bcd_converter #(
   parameter int         WIDTH      = 14,
   parameter logic [3:0] BLANK_CODE = 4'hF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] bin_in,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic [3:0]       dig3,
   output logic [3:0]       dig2,
   output logic [3:0]       dig1,
   output logic [3:0]       dig0,
   output logic             neg,
   output logic             ovf
);
   typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;
   state_t           state;
   logic [19:0]      bcd, adj;
   logic [WIDTH-1:0] sh, mag;
   logic [4:0]       cnt;
   logic             neg_r, is_neg;
   // the most-negative value negates to itself and is then read as unsigned
   assign is_neg = signed_mode & bin_in[WIDTH-1];
   assign mag    = is_neg ? ~bin_in + 1'b1 : bin_in;
   always_comb begin
      adj = bcd;
      for (int i = 0; i < 5; i++)
         adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         bcd   <= '0;
         sh    <= '0;
         cnt   <= '0;
         neg_r <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         dig3  <= '0;
         dig2  <= '0;
         dig1  <= '0;
         dig0  <= '0;
         neg   <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               sh    <= mag;
               neg_r <= is_neg;
               bcd   <= '0;
               cnt   <= 5'(WIDTH);
               busy  <= 1'b1;
               state <= SHIFT;
            end
            SHIFT: begin
               {bcd, sh} <= {adj[18:0], sh, 1'b0};
               cnt       <= cnt - 5'd1;
               state     <= (cnt == 5'd1) ? LATCH : SHIFT;
            end
            // outputs and done update together; busy stays high through the done cycle
            LATCH: begin
               ovf   <= bcd[19:16] != 4'd0;
               neg   <= (bcd[19:16] != 4'd0) ? 1'b0 : neg_r;
               dig3  <= (bcd[19:16] != 4'd0) ? BLANK_CODE : bcd[15:12];
               dig2  <= (bcd[19:16] != 4'd0) ? BLANK_CODE : bcd[11:8];
               dig1  <= (bcd[19:16] != 4'd0) ? BLANK_CODE : bcd[7:4];
               dig0  <= (bcd[19:16] != 4'd0) ? BLANK_CODE : bcd[3:0];
               done  <= 1'b1;
               state <= DONE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
